// File: rtl/mult255_arbiter.sv
// Arbiter that shares one 255-bit modular multiplier among NREQ requesters.
// Round-robin by default; define MULT255_ARB_FIXED_PRIO_EN for fixed priority.
module mult255_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*255-1:0] req_a,
    input  logic [NREQ*255-1:0] req_b,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [254:0]        rsp_data,
    output logic [254:0]        mul_in1,
    output logic [254:0]        mul_in2,
    output logic                mul_start,
    input  logic [254:0]        mul_out,
    output logic                busy,
    output logic [1:0]          owner
);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t     state;
    logic [4:0] cnt;
    logic [1:0] win;
    logic       found;

`ifdef MULT255_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                win   = 2'(i);
            end
        end
    end
`else
    logic [1:0] rr_ptr;
    logic [2:0] idx;

    // Scan downward so the candidate nearest the pointer wins last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = 3'(rr_ptr) + 3'(k);
            if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
            if (req_valid[idx[1:0]]) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !rst) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            owner     <= '0;
`ifndef MULT255_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            mul_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        mul_in1   <= req_a[255*win +: 255];
                        mul_in2   <= req_b[255*win +: 255];
                        owner     <= win;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
`ifndef MULT255_ARB_FIXED_PRIO_EN
                        rr_ptr    <= (win == 2'(NREQ-1)) ? 2'd0 : win + 2'd1;
`endif
                    end
                end
                LOAD: begin
                    cnt   <= 5'(MUL_LAT);
                    state <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        rsp_data  <= mul_out;
                        rsp_valid <= ONE << owner;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult255_arbiter.sv
// Bench for mult255_arbiter: stub multiplier, scoreboard monitor, vector table
// and hand-written sequences for contention, backpressure and reset abort.
module tb_mult255_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 18;
    localparam logic [254:0] P = ~255'd0 - 255'd18;

    logic           clk;
    logic           rst;
    logic [3:0]     req_valid;
    logic [3:0]     req_ready;
    logic [1019:0]  req_a;
    logic [1019:0]  req_b;
    logic [3:0]     rsp_valid;
    logic [3:0]     rsp_ready;
    logic [254:0]   rsp_data;
    logic [254:0]   mul_in1;
    logic [254:0]   mul_in2;
    logic           mul_start;
    logic [254:0]   mul_out;
    logic           busy;
    logic [1:0]     owner;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    mult255_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
        .mul_out(mul_out), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] f;
        f = 510'(a) * 510'(b);
        return 255'(f % 510'(P));
    endfunction

    function automatic int pick(input logic [3:0] v, input int ptr);
`ifdef MULT255_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int k = 0; k < 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Stub multiplier: result valid only exactly MUL_LAT cycles after mul_start falls.
    int scnt = 1000;
    always @(posedge clk) begin
        if (mul_start) scnt <= 0;
        else if (scnt < 1000) scnt <= scnt + 1;
    end
    assign mul_out = (scnt == MUL_LAT - 1) ? mulmod(mul_in1, mul_in2) : ~255'd0;

    typedef struct { int idx; logic [254:0] a; logic [254:0] b; logic [254:0] r; } sb_t;
    typedef struct { int idx; int c; } gl_t;
    sb_t        sb[$];
    gl_t        glog[$];
    int         exp_ptr = 0;
    int         grant_cyc = 0;
    int         w;
    logic [3:0] exp_rdy;
    logic [3:0] prev_rv = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_ptr = 0;
            prev_rv = '0;
        end else begin
            if (busy && sb.size() > 0) begin
                chk("mul_in1_hold", mul_in1, sb[0].a);
                chk("mul_in2_hold", mul_in2, sb[0].b);
            end
            if (|rsp_valid) begin
                if (sb.size() == 0) chk("rsp_unexpected", 255'(rsp_valid), 255'd0);
                else begin
                    chk("rsp_valid", 255'(rsp_valid), 255'(4'b0001 << sb[0].idx));
                    chk("rsp_data", rsp_data, sb[0].r);
                    if (prev_rv == 4'd0)
                        chk("rsp_latency", 255'(cyc - grant_cyc), 255'(MUL_LAT + 2));
                    if (|(rsp_valid & rsp_ready)) void'(sb.pop_front());
                end
            end
            if (mul_start) chk("start_latency", 255'(cyc - grant_cyc), 255'd1);
            exp_rdy = '0;
            w = -1;
            if (!busy && |req_valid) begin
                w = pick(req_valid, exp_ptr);
                exp_rdy = 4'b0001 << w;
            end
            chk("req_ready", 255'(req_ready), 255'(exp_rdy));
            if (w >= 0) begin
                sb.push_back('{w, req_a[255*w +: 255], req_b[255*w +: 255],
                               mulmod(req_a[255*w +: 255], req_b[255*w +: 255])});
                glog.push_back('{w, cyc});
                grant_cyc = cyc;
                exp_ptr = (w + 1) % 4;
            end
            prev_rv = rsp_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        glog.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 255'(n >= 100), 255'd0);
    endtask

    task automatic do_single(input int r, input logic [254:0] a, input logic [254:0] b,
                             input logic [254:0] e);
        int t0;
        int n;
        @(posedge clk); #1;
        req_a[255*r +: 255] = a;
        req_b[255*r +: 255] = b;
        req_valid = 4'b0001 << r;
        @(negedge clk);
        chk("ready_now", 255'(req_ready), 255'(4'b0001 << r));
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (rsp_valid == 4'd0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", 255'(cyc - t0), 255'(MUL_LAT + 2));
        chk("single_valid", 255'(rsp_valid), 255'(4'b0001 << r));
        chk("single_data", rsp_data, e);
        chk("single_owner", 255'(owner), 255'(r));
    endtask

    typedef struct { int r; logic [254:0] a; logic [254:0] b; logic [254:0] e; } vec_t;
    vec_t tv[5];
    int   exp_ord[5];
    int   n;
    int   seen;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tv[0] = '{2, 255'd3, 255'd5, 255'd15};
        tv[1] = '{0, 255'd7, 255'd11, 255'd77};
        tv[2] = '{3, 255'd0, 255'd12345, 255'd0};
        tv[3] = '{1, P - 255'd1, 255'd2, P - 255'd2};
        tv[4] = '{2, 255'd1 << 200, 255'd1 << 100, 255'd19 << 45};

        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 4'hF;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 255'(req_ready), 255'd0);
        chk("rst_rsp_valid", 255'(rsp_valid), 255'd0);
        chk("rst_rsp_data", rsp_data, 255'd0);
        chk("rst_mul_in1", mul_in1, 255'd0);
        chk("rst_mul_in2", mul_in2, 255'd0);
        chk("rst_ctl", 255'({mul_start, busy, owner}), 255'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) do_single(tv[i].r, tv[i].a, tv[i].b, tv[i].e);
        wait_idle();

        // All four requesters contend continuously.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[255*i +: 255] = 255'(i + 2);
            req_b[255*i +: 255] = 255'(i + 10);
        end
        req_valid = 4'hF;
        n = 0;
        while (glog.size() < 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = '0;
`ifdef MULT255_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 255'(i < glog.size() ? glog[i].idx : -1), 255'(exp_ord[i]));
            if (i > 0)
                chk("rr_spacing", 255'(i < glog.size() ? glog[i].c - glog[i-1].c : -1), 255'd21);
        end
        wait_idle();

        // Owner withholds rsp_ready; non-owner ready bits are high and must be ignored.
        rsp_ready = 4'b1101;
        @(posedge clk); #1;
        req_a[255 +: 255] = 255'd9;
        req_b[255 +: 255] = 255'd9;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (rsp_valid == 4'd0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_a[0 +: 255] = 255'd4;
        req_b[0 +: 255] = 255'd4;
        req_valid = 4'b0001;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 255'(rsp_valid), 255'd2);
            chk("bp_data", rsp_data, 255'd81);
            chk("bp_ready", 255'(req_ready), 255'd0);
            chk("bp_busy", 255'(busy), 255'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 4'hF;
        @(negedge clk);
        chk("hs_no_grant", 255'(req_ready), 255'd0);
        @(negedge clk);
        chk("post_hs_busy", 255'(busy), 255'd0);
        chk("post_hs_grant", 255'(req_ready), 255'd1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Reset in the middle of BUSY aborts the transaction.
        @(posedge clk); #1;
        req_a[510 +: 255] = 255'd3;
        req_b[510 +: 255] = 255'd5;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 255'(busy), 255'd0);
        chk("abort_rsp_valid", 255'(rsp_valid), 255'd0);
        chk("abort_mul_in1", mul_in1, 255'd0);
        chk("abort_rsp_data", rsp_data, 255'd0);
        chk("abort_ctl", 255'({mul_start, owner, req_ready}), 255'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (|rsp_valid) seen++;
        end
        chk("abort_no_rsp", 255'(seen), 255'd0);
        do_single(3, 255'd6, 255'd7, 255'd42);
        wait_idle();

        // Requesters 0 and 3 held high together.
        do_reset();
        req_a[0 +: 255] = 255'd5;
        req_b[0 +: 255] = 255'd8;
        req_a[765 +: 255] = 255'd13;
        req_b[765 +: 255] = 255'd2;
        req_valid = 4'b1001;
        n = 0;
        while (glog.size() < 4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = '0;
`ifdef MULT255_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 3, 0, 3, 0};
`endif
        for (int i = 0; i < 4; i++)
            chk("alt_order", 255'(i < glog.size() ? glog[i].idx : -1), 255'(exp_ord[i]));
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
